// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, totals and the
// per-axis phase type used by the counter/FSM and the sync generator.
package vga_pkg;

    // Default 640x480@60 Hz timing, in pixels (horizontal) and lines (vertical)
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CNT_W_DEF    = 10;

    // Sum of the four phases of one axis
    function automatic int axis_total(input int act, input int fp,
                                      input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // Phase of one axis; order matches the scan order within a line/frame
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: a wrapping position counter plus the ACTIVE/FP/SYNC/BP
// phase FSM. Advances only when step is high; wrap_out flags the step that
// takes the counter from TOTAL-1 back to 0 (used to step the next axis).
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step,
    output logic             wrap_out,
    output logic [CNT_W-1:0] cnt,
    output phase_e           phase
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    // Counts must fit the counter, and every phase needs at least one slot
    // or the FSM would skip a state.
    if (TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("vga_axis_cnt: total %0d does not fit in %0d bits", TOTAL, CNT_W);
    end
    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
        $error("vga_axis_cnt: every phase length must be at least 1");
    end

    // Last count of each phase; the FSM leaves a phase on the step taken there
    localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] END_BP   = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q;
    phase_e           phase_q, phase_nxt;

    assign wrap_out = step && (cnt_q == END_BP);
    assign cnt      = cnt_q;
    assign phase    = phase_q;

    // Position counter: 0..TOTAL-1, wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (step)
            cnt_q <= (cnt_q == END_BP) ? '0 : cnt_q + 1'b1;
    end

    // Phase state register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            phase_q <= PH_ACTIVE;
        else
            phase_q <= phase_nxt;
    end

    // Next phase: move on when the step lands on the last count of the phase
    always_comb begin
        phase_nxt = phase_q;
        if (step) begin
            case (phase_q)
                PH_ACTIVE: if (cnt_q == END_ACT)  phase_nxt = PH_FP;
                PH_FP:     if (cnt_q == END_FP)   phase_nxt = PH_SYNC;
                PH_SYNC:   if (cnt_q == END_SYNC) phase_nxt = PH_BP;
                PH_BP:     if (cnt_q == END_BP)   phase_nxt = PH_ACTIVE;
                default:                          phase_nxt = PH_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator (default 640x480@60 on a 25 MHz pixel clock).
// Horizontal and vertical axis counters; the vertical axis steps on the
// horizontal wrap. All outputs are registered one cycle behind the counters.
// Optional: define VGA_SYNC_FRAME_CNT_EN to add a 16-bit frame counter output.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter bit   SYNC_POL = 1'b0,
    parameter int   CNT_W    = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             video_on_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             line_start_o,
    output logic             frame_start_o
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt_o
`endif
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    phase_e           h_phase, v_phase;
    logic             h_wrap;
    logic             v_wrap_unused;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .step     (en_i),
        .wrap_out (h_wrap),
        .cnt      (h_cnt),
        .phase    (h_phase)
    );

    // Vertical axis advances one line per horizontal wrap
    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .step     (h_wrap),
        .wrap_out (v_wrap_unused),
        .cnt      (v_cnt),
        .phase    (v_phase)
    );

    // Output register: sample counter/phase state on enabled cycles; hold
    // otherwise, but drop the strobes so a frozen pixel never repeats one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_o           <= '0;
            y_o           <= '0;
            video_on_o    <= 1'b0;
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (en_i) begin
            x_o           <= h_cnt;
            y_o           <= v_cnt;
            video_on_o    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            hsync_o       <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            line_start_o  <= (h_cnt == '0);
            frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Frame counter: one count per presented frame_start pulse, wraps at 16 bits
    always_ff @(posedge clk_i) begin
        if (rst_i)
            frame_cnt_o <= '0;
        else if (frame_start_o)
            frame_cnt_o <= frame_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. A default-timing instance checks reset,
// line timing, freeze and mid-line reset; a shrunken-timing instance
// (15x8, active-high sync) checks frame-level behaviour within a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default 640x480 instance
    logic       rst_d, en_d;
    logic       hs_d, vs_d, vo_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;

    // Small instance: H 8/2/3/2 (15), V 4/1/2/1 (8), SYNC_POL=1
    logic       rst_s, en_s;
    logic       hs_s, vs_s, vo_s, ls_s, fs_s;
    logic [3:0] x_s, y_s;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] fc_d, fc_s;
`endif

    vga_sync_gen dut (
        .clk_i         (clk),
        .rst_i         (rst_d),
        .en_i          (en_d),
        .hsync_o       (hs_d),
        .vsync_o       (vs_d),
        .video_on_o    (vo_d),
        .x_o           (x_d),
        .y_o           (y_d),
        .line_start_o  (ls_d),
        .frame_start_o (fs_d)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt_o   (fc_d)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1), .CNT_W (4)
    ) dut_s (
        .clk_i         (clk),
        .rst_i         (rst_s),
        .en_i          (en_s),
        .hsync_o       (hs_s),
        .vsync_o       (vs_s),
        .video_on_o    (vo_s),
        .x_o           (x_s),
        .y_o           (y_s),
        .line_start_o  (ls_s),
        .frame_start_o (fs_s)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt_o   (fc_s)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle past the edge before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hs_lo, vs_lo, vs_hi, hs_hi, vo_n, ls_n, fs_n, hs_first, hs_last;
    int vs_first, vs_last, y_max, bad, k;
    bit found;

    initial begin
        rst_d = 1'b1; en_d = 1'b0;
        rst_s = 1'b1; en_s = 1'b0;
        tick(); tick();

        // ---------------- default instance ----------------
        chk("rst_x",   x_d,  0);
        chk("rst_y",   y_d,  0);
        chk("rst_vo",  vo_d, 0);
        chk("rst_hs",  hs_d, 1);
        chk("rst_vs",  vs_d, 1);
        chk("rst_ls",  ls_d, 0);
        chk("rst_fs",  fs_d, 0);

        rst_d = 1'b0; en_d = 1'b1;
        tick();
        chk("first_x",  x_d,  0);
        chk("first_y",  y_d,  0);
        chk("first_vo", vo_d, 1);
        chk("first_ls", ls_d, 1);
        chk("first_fs", fs_d, 1);
        chk("first_hs", hs_d, 1);
        chk("first_vs", vs_d, 1);

        // One full line: outputs 0..799
        hs_lo = 0; vs_lo = 0; vo_n = 0; ls_n = 0; fs_n = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            if (!hs_d) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(x_d);
                hs_last = int'(x_d);
            end
            if (!vs_d) vs_lo++;
            if (vo_d)  vo_n++;
            if (ls_d)  ls_n++;
            if (fs_d)  fs_n++;
        end
        chk("line_hs_low_cycles", hs_lo,    96);
        chk("line_hs_first_x",    hs_first, 656);
        chk("line_hs_last_x",     hs_last,  751);
        chk("line_video_cycles",  vo_n,     640);
        chk("line_ls_count",      ls_n,     1);
        chk("line_fs_count",      fs_n,     1);
        chk("line_vs_low",        vs_lo,    0);

        tick();
        chk("line2_x",  x_d,  0);
        chk("line2_y",  y_d,  1);
        chk("line2_ls", ls_d, 1);
        chk("line2_fs", fs_d, 0);

        // Freeze mid-line at x=300 for 37 cycles
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (x_d == 10'd300) found = 1'b1;
            else tick();
        end
        chk("reach_x300", int'(found), 1);
        en_d = 1'b0;
        bad = 0;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (x_d != 10'd300 || y_d != 10'd1 || vo_d != 1'b1 || ls_d || fs_d || !hs_d)
                bad++;
        end
        chk("freeze_bad_cycles", bad, 0);
        en_d = 1'b1;
        tick();
        chk("resume_x", x_d, 301);
        chk("resume_y", y_d, 1);

        // Reset at x=700 (inside hsync) returns everything to reset values
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (x_d == 10'd700) found = 1'b1;
            else tick();
        end
        chk("reach_x700", int'(found), 1);
        chk("x700_hs", hs_d, 0);
        rst_d = 1'b1;
        tick();
        chk("mrst_x",  x_d,  0);
        chk("mrst_y",  y_d,  0);
        chk("mrst_vo", vo_d, 0);
        chk("mrst_hs", hs_d, 1);
        rst_d = 1'b0;
        tick();
        chk("mrst_next_x",  x_d,  0);
        chk("mrst_next_y",  y_d,  0);
        chk("mrst_next_fs", fs_d, 1);
        en_d = 1'b0;

        // ---------------- small instance ----------------
        chk("s_rst_hs", hs_s, 0);
        chk("s_rst_vs", vs_s, 0);
        chk("s_rst_vo", vo_s, 0);

        rst_s = 1'b0; en_s = 1'b1;
        hs_hi = 0; vs_hi = 0; vo_n = 0; fs_n = 0; ls_n = 0;
        vs_first = -1; vs_last = -1; y_max = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (hs_s) hs_hi++;
            if (vs_s) begin
                vs_hi++;
                if (vs_first < 0) vs_first = int'(y_s);
                vs_last = int'(y_s);
            end
            if (vo_s) vo_n++;
            if (fs_s) fs_n++;
            if (ls_s) ls_n++;
            if (int'(y_s) > y_max) y_max = int'(y_s);
        end
        chk("s_frame_hs_high",  hs_hi,    24);
        chk("s_frame_vs_high",  vs_hi,    30);
        chk("s_frame_vs_first", vs_first, 5);
        chk("s_frame_vs_last",  vs_last,  6);
        chk("s_frame_video",    vo_n,     32);
        chk("s_frame_fs_count", fs_n,     1);
        chk("s_frame_ls_count", ls_n,     8);
        chk("s_frame_y_max",    y_max,    7);
        chk("s_last_x",         x_s,      14);
        chk("s_last_y",         y_s,      7);

        // Simultaneous h/v wrap: next output is x=0,y=0 with frame_start
        tick();
        chk("s_wrap_x",  x_s,  0);
        chk("s_wrap_y",  y_s,  0);
        chk("s_wrap_fs", fs_s, 1);

        // Frame period with 5 disabled cycles inserted: 120 + 5
        found = 1'b0; k = 0; fs_n = 0;
        for (int i = 1; i <= 500 && !found; i++) begin
            en_s = !(i >= 6 && i < 11);
            tick();
            if (fs_s) begin found = 1'b1; k = i; end
        end
        en_s = 1'b1;
        chk("s_frame_period_gap", k, 125);

        // Reset mid-frame at (12,6) with en low: reset values regardless of en
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (x_s == 4'd12 && y_s == 4'd6) found = 1'b1;
            else tick();
        end
        chk("s_reach_12_6", int'(found), 1);
        chk("s_12_6_vs", vs_s, 1);
        rst_s = 1'b1; en_s = 1'b0;
        tick();
        chk("s_mrst_x",  x_s,  0);
        chk("s_mrst_y",  y_s,  0);
        chk("s_mrst_vs", vs_s, 0);
        chk("s_mrst_hs", hs_s, 0);
        chk("s_mrst_vo", vo_s, 0);
        rst_s = 1'b0; en_s = 1'b1;
        tick();
        chk("s_mrst_next_x",  x_s,  0);
        chk("s_mrst_next_y",  y_s,  0);
        chk("s_mrst_next_fs", fs_s, 1);
        chk("s_mrst_next_vo", vo_s, 1);

`ifdef VGA_SYNC_FRAME_CNT_EN
        // Two more frames give three frame_start pulses since reset
        for (int i = 0; i < 240; i++) tick();
        chk("s_fc_pulse3", fs_s, 1);
        tick();
        chk("s_frame_cnt3", fc_s, 3);
        chk("d_frame_cnt1", fc_d, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
